// File: rtl/seq_detector_multi_pkg.sv
// seq_det_pkg: power-on pattern table contents and width helpers for the multi-pattern detector.
package seq_det_pkg;
    localparam int DEF_NUM = 4;
    localparam int DEF_LEN = 5;
    localparam logic [DEF_NUM-1:0][DEF_LEN-1:0] DEF_PAT = {5'b10100, 5'b10101, 5'b01010, 5'b10111};

    typedef struct packed {
        logic [DEF_LEN-1:0] pattern;
        logic [2:0]         len;
    } def_entry_t;

    function automatic int sel_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int len_w(int m);
        return $clog2(m + 1);
    endfunction
endpackage

// File: rtl/seq_detector_multi_if.sv
// seq_detector_multi_if: serial input, pattern-table config and status outputs of the detector.
interface seq_detector_multi_if
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int NUM_PAT = 4,
    parameter int CNT_W   = 16
);
    localparam int SEL_W = sel_w(NUM_PAT);
    localparam int LEN_W = len_w(MAX_LEN);
    logic               in_valid;
    logic               in_bit;
    logic [SEL_W-1:0]   sel;
    logic               overlap;
    logic               cfg_we;
    logic [SEL_W-1:0]   cfg_idx;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               seq_detected;
    logic [CNT_W-1:0]   dseq_count;
    logic               cnt_sat;
    logic [LEN_W-1:0]   fill;
    modport master (
        output in_valid, in_bit, sel, overlap, cfg_we, cfg_idx, cfg_pattern, cfg_len,
        input  seq_detected, dseq_count, cnt_sat, fill
    );
    modport slave (
        input  in_valid, in_bit, sel, overlap, cfg_we, cfg_idx, cfg_pattern, cfg_len,
        output seq_detected, dseq_count, cnt_sat, fill
    );
endinterface

// File: rtl/seq_detector_multi_table.sv
// seq_pattern_table: programmable pattern/length table with clamped writes and a combinational read port.
module seq_pattern_table
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int NUM_PAT = 4,
    parameter int SEL_W   = sel_w(NUM_PAT),
    parameter int LEN_W   = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we_i,
    input  logic [SEL_W-1:0]   idx_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic [MAX_LEN-1:0] pattern_o,
    output logic [LEN_W-1:0]   len_o
);
    typedef struct packed {
        logic [MAX_LEN-1:0] pattern;
        logic [LEN_W-1:0]   len;
    } entry_t;

    entry_t tbl_q [NUM_PAT];

    // Defaults only fit when the table can hold a 5-bit pattern; otherwise every entry starts disabled.
    function automatic entry_t def_entry(int k);
        def_entry = '0;
        if (k < DEF_NUM && MAX_LEN >= DEF_LEN) begin
            def_entry.pattern = MAX_LEN'(DEF_PAT[k]);
            def_entry.len     = LEN_W'(DEF_LEN);
        end
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_PAT; k++) tbl_q[k] <= def_entry(k);
        end else if (we_i && int'(idx_i) < NUM_PAT) begin
            tbl_q[idx_i].pattern <= pattern_i;
            tbl_q[idx_i].len     <= (len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_i;
        end
    end

    assign pattern_o = (int'(sel_i) < NUM_PAT) ? tbl_q[sel_i].pattern : '0;
    assign len_o     = (int'(sel_i) < NUM_PAT) ? tbl_q[sel_i].len : '0;
endmodule

// File: rtl/seq_detector_multi.sv
// seq_detector_multi: serial pattern detector with selectable table entry, overlap mode and saturating hit counter.
module seq_detector_multi
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int NUM_PAT = 4,
    parameter int CNT_W   = 16
) (
    input logic                clk,
    input logic                reset,
    seq_detector_multi_if.slave bus
);
    localparam int SEL_W = sel_w(NUM_PAT);
    localparam int LEN_W = len_w(MAX_LEN);

    logic [MAX_LEN-1:0] hist_q, hist_d, pat, mask;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_inc, len;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q;
    logic               det_q, sat_q, sat_d, hit, clr;

    seq_pattern_table #(.MAX_LEN(MAX_LEN), .NUM_PAT(NUM_PAT), .SEL_W(SEL_W), .LEN_W(LEN_W)) u_table (
        .clk       (clk),
        .reset     (reset),
        .we_i      (bus.cfg_we),
        .idx_i     (bus.cfg_idx),
        .pattern_i (bus.cfg_pattern),
        .len_i     (bus.cfg_len),
        .sel_i     (bus.sel),
        .pattern_o (pat),
        .len_o     (len)
    );

    // Matching is done on the post-shift history so a hit is reported one cycle after its last bit.
    always_comb begin
        hist_d   = bus.in_valid ? {hist_q[MAX_LEN-2:0], bus.in_bit} : hist_q;
        fill_inc = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
        mask     = ~({MAX_LEN{1'b1}} << len);
        hit      = bus.in_valid && (len != '0) && (fill_inc >= len) && (((hist_d ^ pat) & mask) == '0);
        fill_d   = !bus.in_valid ? fill_q : (hit && !bus.overlap) ? '0 : fill_inc;
        clr      = (bus.sel != sel_q) || (bus.cfg_we && bus.cfg_idx == bus.sel);
        cnt_d    = clr ? '0 : (hit && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        sat_d    = !clr && (sat_q || (&cnt_d));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
            det_q  <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
            sel_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            det_q  <= hit;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
            sel_q  <= bus.sel;
        end
    end

    assign bus.seq_detected = det_q;
    assign bus.dseq_count   = cnt_q;
    assign bus.cnt_sat      = sat_q;
    assign bus.fill         = fill_q;
endmodule
